// File: rtl/rob_fill_arb_pkg.sv
// Shared core variables for the ROB fill path: default widths, the fill packet
// and a wrap-around index helper used by the arbiter and its priority encoder.
package rob_fill_arb_pkg;

    localparam int DEF_TAG_W  = 6;
    localparam int DEF_DATA_W = 32;

    typedef struct packed {
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_DATA_W-1:0] data;
    } fill_pkt_t;

    // Next requester index in round-robin order, wrapping n-1 -> 0.
    function automatic int next_ptr(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rob_fill_arb_if.sv
// Requester-side and ROB-fill-side signal bundle of rob_fill_arb.
// master is the arbiter's view; slave is the view of the execution units and ROB.
interface rob_fill_arb_if
    import rob_fill_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int DATA_W  = DEF_DATA_W
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_data;

    logic                      fill_valid;
    logic                      fill_ready;
    logic [TAG_W-1:0]          fill_tag;
    logic [DATA_W-1:0]         fill_data;
    logic [PTR_W-1:0]          fill_src;

    modport master (
        input  req_valid, req_tag, req_data, fill_ready,
        output req_ready, fill_valid, fill_tag, fill_data, fill_src
    );

    modport slave (
        output req_valid, req_tag, req_data, fill_ready,
        input  req_ready, fill_valid, fill_tag, fill_data, fill_src
    );

endinterface

// File: rtl/rob_fill_arb_rr_pick.sv
// Rotating-priority encoder: returns the first set bit of req_i found by
// searching from ptr_i upward, wrapping at NUM_REQ. Purely combinational.
module rob_fill_arb_rr_pick
    import rob_fill_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic               any_o,
    output logic [PTR_W-1:0]   idx_o
);

    logic             found;
    logic [PTR_W-1:0] j;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        any_o = |req_i;
        idx_o = '0;
        found = 1'b0;
        j     = ptr_i;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_i[j]) begin
                idx_o = j;
                found = 1'b1;
            end
            j = PTR_W'(next_ptr(int'(j), NUM_REQ));
        end
    end

endmodule

// File: rtl/rob_fill_arb.sv
// Round-robin arbiter sharing the single ROB fill port among NUM_REQ execution units.
// Each unit owns one holding slot; a stalled grant stays locked until the ROB accepts it.
module rob_fill_arb
    import rob_fill_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    rob_fill_arb_if.master bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] hold_v_q, hold_v_d;
    logic [TAG_W-1:0]   hold_tag_q  [NUM_REQ];
    logic [DATA_W-1:0]  hold_data_q [NUM_REQ];

    logic               lock_v_q, lock_v_d;
    logic [PTR_W-1:0]   lock_idx_q, lock_idx_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;

    logic               pick_any;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   grant;
    logic               fire;
    logic               stall;
    logic [NUM_REQ-1:0] drain;
    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] load;

    rob_fill_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i (hold_v_q),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // A presented-but-unaccepted result keeps the port until the ROB takes it.
    assign grant = lock_v_q ? lock_idx_q : pick_idx;
    assign fire  = pick_any &&  bus.fill_ready;
    assign stall = pick_any && !bus.fill_ready;

    always_comb begin
        drain = '0;
        ready = '0;
        load  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            drain[i] = fire && (grant == PTR_W'(i));
            ready[i] = !rst && !flush && (!hold_v_q[i] || drain[i]);
            load[i]  = bus.req_valid[i] && ready[i];
        end
    end

    assign bus.req_ready = ready;

    always_comb begin
        hold_v_d   = (hold_v_q & ~drain) | load;
        lock_v_d   = stall;
        lock_idx_d = stall ? grant : lock_idx_q;
        ptr_d      = fire ? PTR_W'(next_ptr(int'(grant), NUM_REQ)) : ptr_q;
        if (flush) begin
            hold_v_d   = '0;
            lock_v_d   = 1'b0;
            lock_idx_d = '0;
            ptr_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            hold_v_q   <= '0;
            lock_v_q   <= 1'b0;
            lock_idx_q <= '0;
            ptr_q      <= '0;
        end else begin
            hold_v_q   <= hold_v_d;
            lock_v_q   <= lock_v_d;
            lock_idx_q <= lock_idx_d;
            ptr_q      <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: payload storage is not reset; hold_v_q alone says whether a slot holds a result.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (load[i]) begin
                hold_tag_q[i]  <= bus.req_tag[i*TAG_W +: TAG_W];
                hold_data_q[i] <= bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.fill_valid = pick_any;
    assign bus.fill_src   = pick_any ? grant : '0;
    assign bus.fill_tag   = pick_any ? hold_tag_q[grant]  : '0;
    assign bus.fill_data  = pick_any ? hold_data_q[grant] : '0;

endmodule

// File: tb/tb_rob_fill_arb.sv
// Self-checking bench for rob_fill_arb: directed scenarios with constant expectations,
// then randomized traffic checked against a slot/pointer reference model.
module tb_rob_fill_arb;
    import rob_fill_arb_pkg::*;

    localparam int N  = 4;
    localparam int TW = DEF_TAG_W;
    localparam int DW = DEF_DATA_W;
    localparam int PW = $clog2(N);
    localparam int FW = 1 + PW + TW + DW;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    rob_fill_arb_if #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) bus ();

    rob_fill_arb #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_data  = '0;
    endtask

    task automatic put(input int i, input int tag, input logic [DW-1:0] data);
        bus.req_valid[i]           = 1'b1;
        bus.req_tag[i*TW +: TW]    = TW'(tag);
        bus.req_data[i*DW +: DW]   = data;
    endtask

    function automatic logic [FW-1:0] exp_fill(input logic v, input int src, input int tag,
                                               input logic [DW-1:0] data);
        return {v, PW'(src), TW'(tag), data};
    endfunction

    function automatic logic [FW-1:0] fill_now();
        return {bus.fill_valid, bus.fill_src, bus.fill_tag, bus.fill_data};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        settle();
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready_during: got %b want 0000", bus.req_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        settle();
        checks++;
        if (fill_now() !== exp_fill(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_fill: got %h want %h", fill_now(), exp_fill(0, 0, 0, 0));
        end
        checks++;
        if (bus.req_ready !== 4'b1111) begin
            errors++;
            $display("FAIL reset_ready_after: got %b want 1111", bus.req_ready);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        bus.fill_ready = 1'b1;
        for (int i = 0; i < N; i++) put(i, 5 + i, 32'hA000 + i);
        tick();
        clear_reqs();
        for (int k = 0; k < N; k++) begin
            settle();
            checks++;
            if (fill_now() !== exp_fill(1, k, 5 + k, 32'hA000 + k)) begin
                errors++;
                $display("FAIL simul_fill%0d: got %h want %h", k, fill_now(),
                         exp_fill(1, k, 5 + k, 32'hA000 + k));
            end
            tick();
        end
        settle();
        checks++;
        if (bus.fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_empty: got %b want 0", bus.fill_valid);
        end
        tick();
    endtask

    task automatic test_stall();
        bus.fill_ready = 1'b0;
        put(2, 9, 32'hB009);
        tick();
        clear_reqs();
        put(0, 10, 32'hB010);
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if (fill_now() !== exp_fill(1, 2, 9, 32'hB009)) begin
                errors++;
                $display("FAIL stall_hold%0d: got %h want %h", c, fill_now(),
                         exp_fill(1, 2, 9, 32'hB009));
            end
            if (c == 1) begin
                checks++;
                if (bus.req_ready !== 4'b1010) begin
                    errors++;
                    $display("FAIL stall_ready: got %b want 1010", bus.req_ready);
                end
            end
            tick();
            clear_reqs();
        end
        bus.fill_ready = 1'b1;
        settle();
        checks++;
        if (fill_now() !== exp_fill(1, 2, 9, 32'hB009)) begin
            errors++;
            $display("FAIL stall_release: got %h want %h", fill_now(), exp_fill(1, 2, 9, 32'hB009));
        end
        tick();
        settle();
        checks++;
        if (fill_now() !== exp_fill(1, 0, 10, 32'hB010)) begin
            errors++;
            $display("FAIL stall_next: got %h want %h", fill_now(), exp_fill(1, 0, 10, 32'hB010));
        end
        tick();
        settle();
        checks++;
        if (bus.fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_empty: got %b want 0", bus.fill_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.fill_ready = 1'b1;
        put(1, 20, 32'hC020);
        tick();
        for (int k = 1; k <= 5; k++) begin
            put(1, 20 + k, 32'hC020 + k);
            settle();
            checks++;
            if (fill_now() !== exp_fill(1, 1, 20 + k - 1, 32'hC020 + k - 1)) begin
                errors++;
                $display("FAIL b2b_fill%0d: got %h want %h", k, fill_now(),
                         exp_fill(1, 1, 20 + k - 1, 32'hC020 + k - 1));
            end
            checks++;
            if (bus.req_ready[1] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b want 1", k, bus.req_ready[1]);
            end
            tick();
        end
        clear_reqs();
        settle();
        checks++;
        if (fill_now() !== exp_fill(1, 1, 25, 32'hC025)) begin
            errors++;
            $display("FAIL b2b_last: got %h want %h", fill_now(), exp_fill(1, 1, 25, 32'hC025));
        end
        tick();
    endtask

    task automatic test_flush();
        bus.fill_ready = 1'b0;
        put(0, 30, 32'hD030);
        put(3, 33, 32'hD033);
        tick();
        clear_reqs();
        flush = 1'b1;
        put(2, 34, 32'hD034);
        settle();
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL flush_ready_low: got %b want 0000", bus.req_ready);
        end
        checks++;
        if (bus.fill_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_valid_in_cycle: got %b want 1", bus.fill_valid);
        end
        tick();
        flush = 1'b0;
        clear_reqs();
        settle();
        checks++;
        if ({bus.fill_valid, bus.req_ready} !== 5'b0_1111) begin
            errors++;
            $display("FAIL flush_after: got %b want 01111", {bus.fill_valid, bus.req_ready});
        end
        // Pointer is back at 0, so slot 1 must win over slot 3.
        bus.fill_ready = 1'b1;
        put(1, 31, 32'hD031);
        put(3, 35, 32'hD035);
        tick();
        clear_reqs();
        settle();
        checks++;
        if (fill_now() !== exp_fill(1, 1, 31, 32'hD031)) begin
            errors++;
            $display("FAIL flush_ptr0: got %h want %h", fill_now(), exp_fill(1, 1, 31, 32'hD031));
        end
        tick();
        settle();
        checks++;
        if (fill_now() !== exp_fill(1, 3, 35, 32'hD035)) begin
            errors++;
            $display("FAIL flush_second: got %h want %h", fill_now(), exp_fill(1, 3, 35, 32'hD035));
        end
        tick();
    endtask

    task automatic test_wrap();
        bus.fill_ready = 1'b1;
        put(2, 40, 32'hE040);
        tick();
        clear_reqs();
        put(0, 41, 32'hE041);
        put(3, 42, 32'hE042);
        settle();
        checks++;
        if (fill_now() !== exp_fill(1, 2, 40, 32'hE040)) begin
            errors++;
            $display("FAIL wrap_src2: got %h want %h", fill_now(), exp_fill(1, 2, 40, 32'hE040));
        end
        checks++;
        if (bus.req_ready !== 4'b1111) begin
            errors++;
            $display("FAIL wrap_ready: got %b want 1111", bus.req_ready);
        end
        tick();
        clear_reqs();
        settle();
        checks++;
        if (fill_now() !== exp_fill(1, 3, 42, 32'hE042)) begin
            errors++;
            $display("FAIL wrap_src3: got %h want %h", fill_now(), exp_fill(1, 3, 42, 32'hE042));
        end
        tick();
        settle();
        checks++;
        if (fill_now() !== exp_fill(1, 0, 41, 32'hE041)) begin
            errors++;
            $display("FAIL wrap_src0: got %h want %h", fill_now(), exp_fill(1, 0, 41, 32'hE041));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.fill_ready = 1'b0;
        put(1, 50, 32'hF050);
        tick();
        clear_reqs();
        settle();
        checks++;
        if (fill_now() !== exp_fill(1, 1, 50, 32'hF050)) begin
            errors++;
            $display("FAIL rstmid_before: got %h want %h", fill_now(), exp_fill(1, 1, 50, 32'hF050));
        end
        rst = 1'b1;
        settle();
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_ready_low: got %b want 0000", bus.req_ready);
        end
        tick();
        rst = 1'b0;
        settle();
        checks++;
        if ({fill_now(), bus.req_ready} !== {exp_fill(0, 0, 0, 0), 4'b1111}) begin
            errors++;
            $display("FAIL rstmid_after: got %h/%b want %h/1111", fill_now(), bus.req_ready,
                     exp_fill(0, 0, 0, 0));
        end
    endtask

    // Reference model: each slot is full/empty with a packet; the winner is the full slot
    // at the smallest forward distance from the pointer, unless an earlier stall pinned it.
    task automatic test_random();
        fill_pkt_t     m_slot [N];
        logic [N-1:0]  m_full;
        int            m_ptr;
        int            m_lock;
        logic [N-1:0]  exp_ready;
        logic          exp_v;
        int            g;
        int            best;
        logic [FW-1:0] exp_out;
        logic [FW-1:0] prev_fill;
        logic          prev_stall;
        m_full     = '0;
        m_ptr      = 0;
        m_lock     = -1;
        prev_stall = 1'b0;
        prev_fill  = '0;
        for (int i = 0; i < N; i++) m_slot[i] = '0;
        for (int c = 0; c < 600; c++) begin
            clear_reqs();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) put(i, int'($urandom_range(0, 63)), $urandom);
            end
            bus.fill_ready = ($urandom_range(0, 9) < 6);
            flush          = ($urandom_range(0, 24) == 0);
            settle();

            exp_v = |m_full;
            g     = 0;
            best  = N;
            if (m_lock >= 0) begin
                g = m_lock;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (m_full[i] && ((i - m_ptr + N) % N) < best) begin
                        best = (i - m_ptr + N) % N;
                        g    = i;
                    end
                end
            end
            for (int i = 0; i < N; i++)
                exp_ready[i] = !flush && (!m_full[i] || (exp_v && bus.fill_ready && g == i));
            exp_out = exp_v ? exp_fill(1, g, int'(m_slot[g].tag), m_slot[g].data)
                            : exp_fill(0, 0, 0, 0);

            checks++;
            if (bus.req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready c%0d: got %b want %b", c, bus.req_ready, exp_ready);
            end
            checks++;
            if (fill_now() !== exp_out) begin
                errors++;
                $display("FAIL rand_fill c%0d: got %h want %h", c, fill_now(), exp_out);
            end
            if (prev_stall) begin
                checks++;
                if (fill_now() !== prev_fill) begin
                    errors++;
                    $display("FAIL rand_stable c%0d: got %h want %h", c, fill_now(), prev_fill);
                end
            end
            prev_stall = exp_v && !bus.fill_ready && !flush;
            prev_fill  = exp_out;

            if (flush) begin
                m_full = '0;
                m_ptr  = 0;
                m_lock = -1;
            end else begin
                if (exp_v && bus.fill_ready) begin
                    m_full[g] = 1'b0;
                    m_ptr     = (g + 1) % N;
                    m_lock    = -1;
                end else if (exp_v) begin
                    m_lock = g;
                end
                for (int i = 0; i < N; i++) begin
                    if (bus.req_valid[i] && exp_ready[i]) begin
                        m_full[i]      = 1'b1;
                        m_slot[i].tag  = bus.req_tag[i*TW +: TW];
                        m_slot[i].data = bus.req_data[i*DW +: DW];
                    end
                end
            end
            tick();
        end
        flush = 1'b0;
        clear_reqs();
    endtask

    initial begin
        rst            = 1'b1;
        flush          = 1'b0;
        bus.fill_ready = 1'b0;
        clear_reqs();
        #1;
        test_reset();
        test_simultaneous();
        test_stall();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
